// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package mem_arb_pkg;

  localparam int DEF_DATA_W     = 256;
  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_RD_LAT     = 1;
  localparam int DEF_WR_TIMEOUT = 15;

  localparam logic MEM_RD = 1'b1;
  localparam logic MEM_WR = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and SRAM pin bundle for mem_arbiter; slave = arbiter side, master = environment side.
interface mem_arbiter_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 7
);
  // ReqxValid is held until the cycle ReqxReady is high; the command is taken on that
  // cycle. RspxValid is a single-cycle pulse with RspRData/RspError valid alongside it.
  logic              Req0Valid, Req1Valid;
  logic              Req0Write, Req1Write;
  logic [ADDR_W-1:0] Req0Addr,  Req1Addr;
  logic [DATA_W-1:0] Req0WData, Req1WData;
  logic              Req0Ready, Req1Ready;
  logic              Rsp0Valid, Rsp1Valid;
  logic [DATA_W-1:0] RspRData;
  logic              RspError;
  logic              MemEnable;
  logic              MemReadWrite;
  logic [ADDR_W-1:0] MemAddress;
  logic [DATA_W-1:0] MemDataIn;
  logic [DATA_W-1:0] MemDataOut;
  logic              WriteDone;

  modport slave (
    input  Req0Valid, Req1Valid, Req0Write, Req1Write, Req0Addr, Req1Addr,
           Req0WData, Req1WData, MemDataOut, WriteDone,
    output Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid, RspRData, RspError,
           MemEnable, MemReadWrite, MemAddress, MemDataIn
  );

  modport master (
    output Req0Valid, Req1Valid, Req0Write, Req1Write, Req0Addr, Req1Addr,
           Req0WData, Req1WData, MemDataOut, WriteDone,
    input  Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid, RspRData, RspError,
           MemEnable, MemReadWrite, MemAddress, MemDataIn
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin select; the last-granted index is only updated when update is high.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_q;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset value 1 makes requester 0 the winner of the first contended cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)
      last_q <= 1'b1;
    else if (update && (grant != 2'b00))
      last_q <= grant[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (0) and execute (1) requests onto a single-ported SRAM, one transaction at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int WR_TIMEOUT = DEF_WR_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus,
  output state_t        dbg_state
);

  localparam logic [7:0] RD_LAST = 8'(RD_LAT - 1);
  localparam logic [7:0] WR_LAST = 8'(WR_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [1:0]        grant;
  logic              accept;
  logic              grant_wr;
  logic              owner_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [7:0]        cnt_q;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({bus.Req1Valid, bus.Req0Valid}),
    .update (accept),
    .grant  (grant)
  );

  assign accept    = (state_q == IDLE) && (grant != 2'b00);
  assign grant_wr  = grant[1] ? bus.Req1Write : bus.Req0Write;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = grant_wr ? WRITE : READ;
      READ:  if (cnt_q == RD_LAST) state_d = RESP;
      WRITE: if (bus.WriteDone || (cnt_q == WR_LAST)) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, shared read/write cycle counter, and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q <= grant[1];
            wr_q    <= grant_wr;
            addr_q  <= grant[1] ? bus.Req1Addr  : bus.Req0Addr;
            wdata_q <= grant[1] ? bus.Req1WData : bus.Req0WData;
            err_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        READ: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == RD_LAST)
            rdata_q <= bus.MemDataOut;
        end
        WRITE: begin
          cnt_q <= cnt_q + 8'd1;
          // WriteDone on the timeout cycle still counts as success.
          if (!bus.WriteDone && (cnt_q == WR_LAST))
            err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.Req0Ready    = 1'b0;
    bus.Req1Ready    = 1'b0;
    bus.Rsp0Valid    = 1'b0;
    bus.Rsp1Valid    = 1'b0;
    bus.RspError     = 1'b0;
    bus.MemEnable    = 1'b0;
    bus.MemReadWrite = 1'b0;
    bus.MemAddress   = '0;
    bus.MemDataIn    = '0;
    case (state_q)
      IDLE: begin
        bus.Req0Ready = grant[0];
        bus.Req1Ready = grant[1];
      end
      READ: begin
        bus.MemEnable    = 1'b1;
        bus.MemReadWrite = MEM_RD;
        bus.MemAddress   = addr_q;
      end
      WRITE: begin
        bus.MemEnable    = 1'b1;
        bus.MemReadWrite = MEM_WR;
        bus.MemAddress   = addr_q;
        bus.MemDataIn    = wdata_q;
      end
      RESP: begin
        bus.Rsp0Valid = !owner_q;
        bus.Rsp1Valid = owner_q;
        bus.RspError  = err_q && wr_q;
      end
      default: ;
    endcase
  end

  assign bus.RspRData = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural SRAM model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     pass_cnt;
  int     total_cnt;

  mem_arbiter_if #(.DATA_W(256), .ADDR_W(7)) bus ();

  mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: combinational read, write on WriteDone, preload port for setup.
  logic [255:0] mem [128];
  logic         preload_en;
  logic [6:0]   preload_addr;
  logic [255:0] preload_data;

  assign bus.MemDataOut = mem[bus.MemAddress];

  always @(posedge clk) begin
    if (preload_en)
      mem[preload_addr] <= preload_data;
    else if (bus.MemEnable && !bus.MemReadWrite && bus.WriteDone)
      mem[bus.MemAddress] <= bus.MemDataIn;
  end

  logic both_ready_seen;
  always @(negedge clk)
    if (bus.Req0Ready && bus.Req1Ready) both_ready_seen = 1'b1;

  logic [255:0] d_aa40, d_aa248, d_w0, d_w1, d_sim;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [6:0] a, input logic [255:0] d);
    preload_addr = a;
    preload_data = d;
    preload_en   = 1'b1;
    tick();
    preload_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    preload(7'h05, d_aa40);
    preload(7'h00, d_w0);
    preload(7'h01, d_w1);
    tick();
    total_cnt++;
    if ({bus.Req0Ready, bus.Req1Ready, bus.Rsp0Valid, bus.Rsp1Valid, bus.RspError,
         bus.MemEnable, bus.MemReadWrite} !== 7'b0)
      $display("FAIL reset_ctl got=%b exp=0000000", {bus.Req0Ready, bus.Req1Ready,
               bus.Rsp0Valid, bus.Rsp1Valid, bus.RspError, bus.MemEnable, bus.MemReadWrite});
    else pass_cnt++;
    total_cnt++;
    if (bus.MemAddress !== 7'h00) $display("FAIL reset_addr got=%h exp=0", bus.MemAddress);
    else pass_cnt++;
    total_cnt++;
    if (bus.RspRData !== 256'h0) $display("FAIL reset_rdata got=%h exp=0", bus.RspRData);
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    bus.Req0Valid = 1'b1; bus.Req0Write = 1'b0; bus.Req0Addr = 7'h05;
    #1;
    total_cnt++;
    if ({bus.Req0Ready, bus.Req1Ready} !== 2'b10)
      $display("FAIL rd_ready got=%b exp=10", {bus.Req0Ready, bus.Req1Ready});
    else pass_cnt++;
    tick();
    bus.Req0Valid = 1'b0;
    total_cnt++;
    if ({bus.MemEnable, bus.MemReadWrite, bus.MemAddress} !== {2'b11, 7'h05})
      $display("FAIL rd_issue got=%b exp=%b", {bus.MemEnable, bus.MemReadWrite, bus.MemAddress},
               {2'b11, 7'h05});
    else pass_cnt++;
    total_cnt++;
    if ({bus.Req0Ready, bus.Rsp0Valid} !== 2'b00)
      $display("FAIL rd_early got=%b exp=00", {bus.Req0Ready, bus.Rsp0Valid});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.Rsp0Valid, bus.Rsp1Valid, bus.RspError, bus.MemEnable} !== 4'b1000)
      $display("FAIL rd_rsp got=%b exp=1000", {bus.Rsp0Valid, bus.Rsp1Valid, bus.RspError,
               bus.MemEnable});
    else pass_cnt++;
    total_cnt++;
    if (bus.RspRData !== d_aa40) $display("FAIL rd_data got=%h exp=%h", bus.RspRData, d_aa40);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.Rsp0Valid, dbg_state} !== {1'b0, IDLE})
      $display("FAIL rd_done got=%b exp=%b", {bus.Rsp0Valid, dbg_state}, {1'b0, IDLE});
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    bus.Req1Valid = 1'b1; bus.Req1Write = 1'b1; bus.Req1Addr = 7'h07; bus.Req1WData = d_aa248;
    #1;
    total_cnt++;
    if ({bus.Req0Ready, bus.Req1Ready} !== 2'b01)
      $display("FAIL wr_ready got=%b exp=01", {bus.Req0Ready, bus.Req1Ready});
    else pass_cnt++;
    tick();
    bus.Req1Valid = 1'b0;
    bus.Req1WData = '1;
    total_cnt++;
    if ({bus.MemEnable, bus.MemReadWrite, bus.MemAddress} !== {2'b10, 7'h07})
      $display("FAIL wr_issue got=%b exp=%b", {bus.MemEnable, bus.MemReadWrite, bus.MemAddress},
               {2'b10, 7'h07});
    else pass_cnt++;
    total_cnt++;
    if (bus.MemDataIn !== d_aa248) $display("FAIL wr_din got=%h exp=%h", bus.MemDataIn, d_aa248);
    else pass_cnt++;
    tick();
    bus.WriteDone = 1'b1;
    tick();
    bus.WriteDone = 1'b0;
    total_cnt++;
    if ({bus.Rsp0Valid, bus.Rsp1Valid, bus.RspError} !== 3'b010)
      $display("FAIL wr_rsp got=%b exp=010", {bus.Rsp0Valid, bus.Rsp1Valid, bus.RspError});
    else pass_cnt++;
    total_cnt++;
    if (bus.RspRData !== d_aa40) $display("FAIL wr_keep_rdata got=%h exp=%h", bus.RspRData, d_aa40);
    else pass_cnt++;
    tick();
    bus.Req1Valid = 1'b1; bus.Req1Write = 1'b0; bus.Req1Addr = 7'h07;
    #1;
    total_cnt++;
    if (bus.Req1Ready !== 1'b1) $display("FAIL rb_ready got=%b exp=1", bus.Req1Ready);
    else pass_cnt++;
    tick();
    bus.Req1Valid = 1'b0;
    tick();
    total_cnt++;
    if ({bus.Rsp1Valid, bus.RspError} !== 2'b10)
      $display("FAIL rb_rsp got=%b exp=10", {bus.Rsp1Valid, bus.RspError});
    else pass_cnt++;
    total_cnt++;
    if (bus.RspRData !== d_aa248) $display("FAIL rb_data got=%h exp=%h", bus.RspRData, d_aa248);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_contention();
    logic g;
    logic found;
    both_ready_seen = 1'b0;
    bus.Req0Valid = 1'b1; bus.Req0Write = 1'b0; bus.Req0Addr = 7'h00;
    bus.Req1Valid = 1'b1; bus.Req1Write = 1'b0; bus.Req1Addr = 7'h01;
    for (int t = 0; t < 4; t++) begin
      #1;
      found = bus.Req0Ready || bus.Req1Ready;
      for (int w = 0; w < 10 && !found; w++) begin
        tick();
        found = bus.Req0Ready || bus.Req1Ready;
      end
      total_cnt++;
      if (!found) begin
        $display("FAIL cont_wait txn=%0d got=no_ready exp=ready", t);
      end else begin
        pass_cnt++;
        g = bus.Req1Ready;
        total_cnt++;
        if (g !== 1'(t % 2)) $display("FAIL cont_order txn=%0d got=%0b exp=%0d", t, g, t % 2);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if ({bus.Rsp1Valid, bus.Rsp0Valid} !== (g ? 2'b10 : 2'b01) ||
            bus.RspRData !== (g ? d_w1 : d_w0))
          $display("FAIL cont_rsp txn=%0d got=%b/%h exp=%b/%h", t, {bus.Rsp1Valid, bus.Rsp0Valid},
                   bus.RspRData, (g ? 2'b10 : 2'b01), (g ? d_w1 : d_w0));
        else pass_cnt++;
        tick();
      end
    end
    bus.Req0Valid = 1'b0;
    bus.Req1Valid = 1'b0;
    total_cnt++;
    if (both_ready_seen !== 1'b0) $display("FAIL cont_both_ready got=1 exp=0");
    else pass_cnt++;
    tick();
  endtask

  task automatic test_timeout();
    int en_cycles;
    bus.Req0Valid = 1'b1; bus.Req0Write = 1'b1; bus.Req0Addr = 7'h10; bus.Req0WData = d_w1;
    bus.WriteDone = 1'b0;
    tick();
    bus.Req0Valid = 1'b0;
    en_cycles = 0;
    for (int i = 0; i < 40 && bus.MemEnable; i++) begin
      en_cycles++;
      tick();
    end
    total_cnt++;
    if (en_cycles != 15) $display("FAIL to_enable_cycles got=%0d exp=15", en_cycles);
    else pass_cnt++;
    total_cnt++;
    if ({bus.Rsp0Valid, bus.Rsp1Valid, bus.RspError} !== 3'b101)
      $display("FAIL to_rsp got=%b exp=101", {bus.Rsp0Valid, bus.Rsp1Valid, bus.RspError});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.Rsp0Valid, dbg_state} !== {1'b0, IDLE})
      $display("FAIL to_idle got=%b exp=%b", {bus.Rsp0Valid, dbg_state}, {1'b0, IDLE});
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    bus.Req0Valid = 1'b1; bus.Req0Write = 1'b1; bus.Req0Addr = 7'h11; bus.Req0WData = d_sim;
    tick();
    bus.Req0Valid = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    total_cnt++;
    if ({bus.MemEnable, bus.MemReadWrite} !== 2'b10)
      $display("FAIL sim_cycle15 got=%b exp=10", {bus.MemEnable, bus.MemReadWrite});
    else pass_cnt++;
    bus.WriteDone = 1'b1;
    tick();
    bus.WriteDone = 1'b0;
    total_cnt++;
    if ({bus.Rsp0Valid, bus.RspError} !== 2'b10)
      $display("FAIL sim_rsp got=%b exp=10", {bus.Rsp0Valid, bus.RspError});
    else pass_cnt++;
    total_cnt++;
    if (mem[7'h11] !== d_sim) $display("FAIL sim_mem got=%h exp=%h", mem[7'h11], d_sim);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_write();
    bus.Req1Valid = 1'b1; bus.Req1Write = 1'b1; bus.Req1Addr = 7'h20; bus.Req1WData = d_w0;
    tick();
    bus.Req1Valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    total_cnt++;
    if ({bus.Req0Ready, bus.Req1Ready, bus.Rsp0Valid, bus.Rsp1Valid, bus.RspError,
         bus.MemEnable, bus.MemReadWrite} !== 7'b0)
      $display("FAIL rst_mid_ctl got=%b exp=0000000", {bus.Req0Ready, bus.Req1Ready,
               bus.Rsp0Valid, bus.Rsp1Valid, bus.RspError, bus.MemEnable, bus.MemReadWrite});
    else pass_cnt++;
    total_cnt++;
    if ({bus.MemAddress, bus.MemDataIn, bus.RspRData} !== '0)
      $display("FAIL rst_mid_bus got=%h/%h exp=0/0", bus.MemAddress, bus.RspRData);
    else pass_cnt++;
    rst_n = 1'b1;
    bus.Req0Valid = 1'b1; bus.Req0Write = 1'b0; bus.Req0Addr = 7'h00;
    bus.Req1Valid = 1'b1; bus.Req1Write = 1'b0; bus.Req1Addr = 7'h01;
    #1;
    total_cnt++;
    if ({bus.Req0Ready, bus.Req1Ready} !== 2'b10)
      $display("FAIL rst_first_grant got=%b exp=10", {bus.Req0Ready, bus.Req1Ready});
    else pass_cnt++;
    tick();
    bus.Req0Valid = 1'b0;
    bus.Req1Valid = 1'b0;
    tick();
    total_cnt++;
    if ({bus.Rsp0Valid, bus.Rsp1Valid} !== 2'b10 || bus.RspRData !== d_w0)
      $display("FAIL rst_post_rsp got=%b/%h exp=10/%h", {bus.Rsp0Valid, bus.Rsp1Valid},
               bus.RspRData, d_w0);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    preload_en = 1'b0; preload_addr = '0; preload_data = '0;
    both_ready_seen = 1'b0;
    bus.Req0Valid = 1'b0; bus.Req0Write = 1'b0; bus.Req0Addr = '0; bus.Req0WData = '0;
    bus.Req1Valid = 1'b0; bus.Req1Write = 1'b0; bus.Req1Addr = '0; bus.Req1WData = '0;
    bus.WriteDone = 1'b0;
    d_aa40  = 256'hAA;  d_aa40  = d_aa40 << 40;
    d_aa248 = 256'hAA;  d_aa248 = d_aa248 << 248;
    d_w0    = 256'h1234_5678_9ABC_DEF0;
    d_w1    = 256'h0F0F_0000_C3C3;  d_w1 = d_w1 << 100;
    d_sim   = 256'h5A5A_A5A5;       d_sim = d_sim << 17;

    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_timeout();
    test_simultaneous();
    test_reset_mid_write();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=stuck exp=finish");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer for the single-ported 256-bit SRAM (128 words, 7-bit address) used by the simple CISC processor.
- Requester 0 is instruction fetch; requester 1 is execute/data access.
- Accepts one request at a time under round-robin priority, drives the SRAM enable/read-write/address/data pins, waits for read latency or the SRAM's WriteDone, then returns a one-cycle response to the owning requester.

Parameters:
- DATA_W, 256, SRAM word width.
- ADDR_W, 7, SRAM address width.
- RD_LAT, 1, cycles from read issue until SRAM DataOut is valid (legal range 1-4).
- WR_TIMEOUT, 15, max cycles to wait for WriteDone before flagging an error (legal range 1-255).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- Req0Valid / Req1Valid  in  1  request pending; held until the matching ReqReady.
- Req0Write / Req1Write  in  1  1 = write, 0 = read.
- Req0Addr / Req1Addr  in  ADDR_W  word address.
- Req0WData / Req1WData  in  DATA_W  write data.
- Req0Ready / Req1Ready  out  1  one-cycle accept pulse; command is latched on this cycle.
- Rsp0Valid / Rsp1Valid  out  1  one-cycle completion pulse.
- RspRData  out  DATA_W  read data, valid with RspxValid; shared by both requesters.
- RspError  out  1  write timed out; valid with RspxValid.
- MemEnable  out  1  SRAM enable.
- MemReadWrite  out  1  1 = read, 0 = write.
- MemAddress  out  ADDR_W  SRAM address.
- MemDataIn  out  DATA_W  write data to SRAM.
- MemDataOut  in  DATA_W  read data from SRAM.
- WriteDone  in  1  SRAM write-complete strobe.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs go to 0; RspRData clears to 0.
  - State returns to IDLE; round-robin pointer set so requester 0 wins first.
  - Reset mid-transaction aborts it; no response is ever issued for the aborted command.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - With no valid requests, stay in IDLE; MemEnable=0.
  - With exactly one valid request, that requester is selected.
  - With both valid, the requester not granted last is selected.
  - On selection, pulse the selected ReqxReady for one cycle; latch owner, write flag, address and data; advance the pointer.
  - Next state: READ or WRITE.
  - The accept cycle issues nothing to the SRAM.
- READ:
  - MemEnable=1, MemReadWrite=1, MemAddress=latched address for RD_LAT cycles.
  - On the final cycle, capture MemDataOut into RspRData and go to RESP.
- WRITE:
  - MemEnable=1, MemReadWrite=0, MemAddress and MemDataIn driven from latched values.
  - A counter starts at 0 on entry.
  - WriteDone=1 sampled: go to RESP with RspError=0.
  - Counter reaches WR_TIMEOUT-1 without WriteDone: go to RESP with RspError=1.
  - If WriteDone and the timeout coincide, WriteDone wins (no error).
  - RspRData is unchanged by writes.
- RESP:
  - MemEnable=0; pulse the owner's RspxValid for one cycle; return to IDLE.
  - A new accept may occur the cycle after RESP.
- Latency:
  - Read: accept at cycle N, RspValid at cycle N+RD_LAT+1.
  - Write: RspValid the cycle after WriteDone is sampled.
- Flow: at most one outstanding transaction. ReqReady is never asserted outside IDLE. Requests arriving during a transaction wait.
- Request-line changes:
  - Changing ReqValid before Ready is legal; the arbiter reacts to the current level.
  - Address/data changes after Ready have no effect.
- Address wrap: none; address is used verbatim, 0x00-0x7F.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE/READ/WRITE/RESP);
  - constants MEM_RD=1'b1 and MEM_WR=1'b0;
  - default widths.
- One sub-module, rr_arbiter2: a 2-input round-robin select with last-grant register, sync active-low reset, and an update-enable input.

Test Plan:
- Single read:
  - Stimulus: after reset, Req0 read addr 0x05 (SRAM preloaded 0xAA<<40).
  - Required: Req0Ready at N; MemEnable=1 with MemReadWrite=1 at N+1; Rsp0Valid at N+2; RspRData=0xAA<<40; RspError=0.
- Write then read-back:
  - Stimulus: Req1 write 0x07, data 0xAA<<248; WriteDone returned 2 cycles into WRITE; then Req1 read 0x07.
  - Required: Rsp1Valid with RspError=0; read returns 0xAA<<248.
- Contention:
  - Stimulus: both requesters hold reads (addr 0x00, 0x01) for 4 transactions.
  - Required: grant order 0,1,0,1; no cycle with both Ready bits high.
- Write timeout:
  - Stimulus: write with WriteDone tied 0.
  - Required: MemEnable held exactly 15 cycles; RspxValid with RspError=1; FSM back in IDLE.
- Reset mid-write:
  - Stimulus: rst_n=0 on the 3rd WRITE cycle.
  - Required: next cycle all outputs 0, no RspValid; a post-reset dual request is granted to requester 0.
- Simultaneous WriteDone and timeout:
  - Stimulus: WriteDone asserted on cycle 15.
  - Required: RspError=0.
